// File: rtl/irq_defs.sv
// Shared definitions for the interrupt controller: source count,
// FSM state encodings and register word offsets.
package irq_defs;

  localparam int NSRC = 6;
  localparam int IDW  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_SERV = 2'b10
  } state_t;

  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_PEND = 2'd2;
  localparam logic [1:0] ADDR_STAT = 2'd3;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index and whether any bit is set.
module irq_prio_enc #(
  parameter int N   = 6,
  parameter int IDW = 3
) (
  input  logic [N-1:0]   req,
  output logic [IDW-1:0] idx,
  output logic           valid
);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches source events into PEND, masks them, and
// hands the highest-priority one to the CPU through a REQ/SERV handshake.
module irq_ctrl #(
  parameter int NSRC = irq_defs::NSRC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      addr,
  input  logic [31:0]     WD,
  input  logic            WE,
  output logic [31:0]     RD,
  input  logic [NSRC-1:0] src,
  input  logic            ack,
  input  logic            eoi,
  output logic            irq
);
  import irq_defs::*;

  logic            en_q;
  logic            edge_q;
  logic            armed_q;
  logic [NSRC-1:0] mask_q;
  logic [NSRC-1:0] pend_q;
  logic [NSRC-1:0] prev_q;
  logic [NSRC-1:0] set_vec;
  logic [NSRC-1:0] clr_vec;
  logic [NSRC-1:0] active;
  logic [IDW-1:0]  cur_id_q;
  logic [IDW-1:0]  win_id;
  logic            win_valid;
  logic            grant;
  logic            wr_ctrl;
  logic            wr_mask;
  logic            wr_pend;
  logic            wd_unused;
  state_t          state_q;
  state_t          state_d;

  assign wr_ctrl   = WE && (addr == ADDR_CTRL);
  assign wr_mask   = WE && (addr == ADDR_MASK);
  assign wr_pend   = WE && (addr == ADDR_PEND);
  assign active    = pend_q & mask_q;
  assign wd_unused = ^WD[31:NSRC];

  irq_prio_enc #(
    .N   (NSRC),
    .IDW (IDW)
  ) u_prio (
    .req   (active),
    .idx   (win_id),
    .valid (win_valid)
  );

  // Set events: rising edges or levels, suppressed on the first edge after reset
  always_comb begin
    set_vec = '0;
    if (armed_q) begin
      set_vec = edge_q ? (src & ~prev_q) : src;
    end
  end

  // Next-state logic; a grant in REQ also clears the winner's pending bit
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_q && win_valid) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (!en_q || !win_valid) begin
          state_d = ST_IDLE;
        end else if (ack) begin
          state_d = ST_SERV;
          grant   = 1'b1;
        end
      end
      ST_SERV: begin
        if (eoi) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Clear sources: software W1C and the grant; set events are applied after, so they win
  always_comb begin
    clr_vec = '0;
    if (wr_pend) clr_vec = WD[NSRC-1:0];
    if (grant) clr_vec = clr_vec | (NSRC'(1) << win_id);
  end

  // FSM state, registered irq and the granted source id
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      irq      <= 1'b0;
      cur_id_q <= '0;
    end else begin
      state_q <= state_d;
      irq     <= (state_d == ST_REQ);
      if (grant) cur_id_q <= win_id;
    end
  end

  // Programmable registers, pending bits and the edge-detect history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q    <= 1'b0;
      edge_q  <= 1'b0;
      mask_q  <= '0;
      pend_q  <= '0;
      prev_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      prev_q  <= src;
      pend_q  <= (pend_q & ~clr_vec) | set_vec;
      if (wr_ctrl) begin
        en_q   <= WD[0];
        edge_q <= WD[1];
      end
      if (wr_mask) mask_q <= WD[NSRC-1:0];
    end
  end

  // Combinational register read mux; unimplemented bits read as zero
  always_comb begin
    RD = '0;
    case (addr)
      ADDR_CTRL: RD = {30'd0, edge_q, en_q};
      ADDR_MASK: RD[NSRC-1:0] = mask_q;
      ADDR_PEND: RD[NSRC-1:0] = pend_q;
      default:   RD = {25'd0, cur_id_q, 2'b00, state_q};
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: a behavioural model tracks the controller and is compared
// with the DUT every cycle, with directed scenarios pinned by literal values.
module tb_irq_ctrl;

  localparam int N = 6;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  addr  = '0;
  logic [31:0] WD    = '0;
  logic        WE    = 1'b0;
  logic [31:0] RD;
  logic [N-1:0] src  = '0;
  logic        ack   = 1'b0;
  logic        eoi   = 1'b0;
  logic        irq;

  int checks = 0;
  int errors = 0;

  int m_mode;
  int m_pend;
  int m_mask;
  int m_prev;
  int m_cur;
  bit m_en;
  bit m_edge;
  bit m_armed;
  bit m_irq;

  always #5 clk = ~clk;

  irq_ctrl #(.NSRC(N)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .WD    (WD),
    .WE    (WE),
    .RD    (RD),
    .src   (src),
    .ack   (ack),
    .eoi   (eoi),
    .irq   (irq)
  );

  function automatic int lowest(input int v);
    for (int i = 0; i < N; i++) begin
      if (((v >> i) & 1) == 1) return i;
    end
    return -1;
  endfunction

  function automatic int model_rd(input int a);
    case (a)
      0:       return (int'(m_edge) << 1) | int'(m_en);
      1:       return m_mask;
      2:       return m_pend;
      default: return (m_cur << 4) | m_mode;
    endcase
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_pend  = 0;
    m_mask  = 0;
    m_prev  = 0;
    m_cur   = 0;
    m_en    = 0;
    m_edge  = 0;
    m_armed = 0;
    m_irq   = 0;
  endtask

  // Advance the model by one clock using the inputs presented this cycle
  task automatic model_step();
    int s;
    int active;
    int win;
    int set;
    int clr;
    int nmode;
    s      = int'(src);
    active = m_pend & m_mask;
    win    = lowest(active);
    set    = 0;
    if (m_armed) set = m_edge ? (s & ~m_prev & 'h3F) : s;
    clr = 0;
    if (WE && addr == 2'd2) clr = int'(WD[5:0]);
    nmode = m_mode;
    if (m_mode == 0) begin
      if (m_en && win >= 0) nmode = 1;
    end else if (m_mode == 1) begin
      if (!m_en || win < 0) nmode = 0;
      else if (ack) begin
        nmode = 2;
        m_cur = win;
        clr   = clr | (1 << win);
      end
    end else begin
      if (eoi) nmode = 0;
    end
    if (WE && addr == 2'd0) begin
      m_en   = WD[0];
      m_edge = WD[1];
    end
    if (WE && addr == 2'd1) m_mask = int'(WD[5:0]);
    m_pend  = ((m_pend & ~clr) | set) & 'h3F;
    m_prev  = s;
    m_armed = 1;
    m_mode  = nmode;
    m_irq   = (nmode == 1);
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all(input string tag);
    check_output({tag, "_irq"}, {31'd0, irq}, {31'd0, m_irq});
    check_output({tag, "_rd"}, RD, model_rd(int'(addr)));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all("model");
  endtask

  task automatic peek(input string name, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check_output(name, RD, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    WE   = 1'b1;
    addr = a;
    WD   = d;
    cycle();
    WE = 1'b0;
    WD = '0;
  endtask

  // Called just after a falling edge; reset is released well before the next rising edge
  task automatic do_reset();
    reset = 1'b1;
    ack   = 1'b0;
    eoi   = 1'b0;
    WE    = 1'b0;
    src   = '0;
    #2;
    model_reset();
    compare_all("reset");
    reset = 1'b0;
  endtask

  task automatic apply_stimulus();
    WE   = ($urandom % 8) == 0;
    addr = 2'($urandom % 4);
    WD   = $urandom;
    if (WE && addr == 2'd0 && ($urandom % 4) != 0) WD[0] = 1'b1;
    if (($urandom % 4) == 0) src = N'($urandom);
    ack = ($urandom % 4) == 0;
    eoi = ($urandom % 6) == 0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);

    // Edge-triggered single source through grant and end-of-interrupt
    do_reset();
    wr(2'd0, 32'h3);
    wr(2'd1, 32'h1);
    src = 6'h01;
    cycle();
    peek("t1_pend_set", 2'd2, 32'h01);
    check_output("t1_irq_not_yet", {31'd0, irq}, 32'd0);
    cycle();
    check_output("t1_irq_up", {31'd0, irq}, 32'd1);
    peek("t1_stat_req", 2'd3, 32'h01);
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    peek("t1_stat_serv", 2'd3, 32'h02);
    peek("t1_pend_clr", 2'd2, 32'h00);
    check_output("t1_irq_after_ack", {31'd0, irq}, 32'd0);
    eoi = 1'b1;
    cycle();
    eoi = 1'b0;
    peek("t1_stat_idle", 2'd3, 32'h00);
    src = '0;

    // Two simultaneous sources served lowest index first
    do_reset();
    wr(2'd0, 32'h3);
    wr(2'd1, 32'h3F);
    src = 6'h06;
    cycle();
    src = '0;
    peek("t2_pend_both", 2'd2, 32'h06);
    cycle();
    check_output("t2_irq_up", {31'd0, irq}, 32'd1);
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    peek("t2_stat_id1", 2'd3, 32'h12);
    peek("t2_pend_left", 2'd2, 32'h04);
    eoi = 1'b1;
    cycle();
    eoi = 1'b0;
    check_output("t2_irq_idle", {31'd0, irq}, 32'd0);
    peek("t2_stat_hold_id", 2'd3, 32'h10);
    cycle();
    check_output("t2_irq_again", {31'd0, irq}, 32'd1);
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    peek("t2_stat_id2", 2'd3, 32'h22);
    peek("t2_pend_empty", 2'd2, 32'h00);

    // Software clears the only pending bit while requesting
    do_reset();
    wr(2'd0, 32'h3);
    wr(2'd1, 32'h3F);
    src = 6'h02;
    cycle();
    src = '0;
    cycle();
    check_output("t3_irq_up", {31'd0, irq}, 32'd1);
    wr(2'd2, 32'h02);
    peek("t3_pend_w1c", 2'd2, 32'h00);
    cycle();
    check_output("t3_irq_drop", {31'd0, irq}, 32'd0);
    peek("t3_stat_idle", 2'd3, 32'h00);
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    peek("t3_ack_ignored", 2'd3, 32'h00);

    // New event during service waits for eoi
    do_reset();
    wr(2'd0, 32'h3);
    wr(2'd1, 32'h1);
    src = 6'h01;
    cycle();
    cycle();
    src = '0;
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    src = 6'h01;
    cycle();
    peek("t4_pend_in_serv", 2'd2, 32'h01);
    cycle();
    check_output("t4_irq_held", {31'd0, irq}, 32'd0);
    peek("t4_stat_serv", 2'd3, 32'h02);
    eoi = 1'b1;
    cycle();
    eoi = 1'b0;
    check_output("t4_irq_idle", {31'd0, irq}, 32'd0);
    cycle();
    check_output("t4_irq_reassert", {31'd0, irq}, 32'd1);
    src = '0;

    // Set wins over same-cycle W1C; eoi beats ack in service
    do_reset();
    wr(2'd0, 32'h3);
    wr(2'd1, 32'h3F);
    src  = 6'h08;
    WE   = 1'b1;
    addr = 2'd2;
    WD   = 32'h08;
    cycle();
    WE = 1'b0;
    WD = '0;
    peek("t5_set_wins", 2'd2, 32'h08);
    cycle();
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    peek("t5_stat_id3", 2'd3, 32'h32);
    ack = 1'b1;
    eoi = 1'b1;
    cycle();
    ack = 1'b0;
    eoi = 1'b0;
    peek("t5_stat_eoi_wins", 2'd3, 32'h30);
    src = '0;

    // Asynchronous reset while in service clears everything immediately
    do_reset();
    wr(2'd0, 32'h3);
    wr(2'd1, 32'h3F);
    src = 6'h01;
    cycle();
    src = '0;
    cycle();
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    src = 6'h04;
    cycle();
    src = '0;
    #1;
    reset = 1'b1;
    #1;
    check_output("t6_irq_rst", {31'd0, irq}, 32'd0);
    peek("t6_ctrl_rst", 2'd0, 32'h0);
    peek("t6_mask_rst", 2'd1, 32'h0);
    peek("t6_pend_rst", 2'd2, 32'h0);
    peek("t6_stat_rst", 2'd3, 32'h0);
    @(negedge clk);
    model_reset();
    reset = 1'b0;

    // Randomized traffic against the model with occasional resets
    for (int n = 0; n < 3000; n++) begin
      if (($urandom % 600) == 0) do_reset();
      apply_stimulus();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
